// File: rtl/dct_pkg.sv
// Shared types and constants for the 8-point DCT-II stage: cosine coefficient
// generation, accumulator sizing and the output sequencer state type.
package dct_pkg;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_t;

  localparam int COS_FRAC_BITS = 20;

  // cos(m*pi/16) for m = 0..8, scaled by 2^COS_FRAC_BITS
  localparam int COS_TAB [0:8] = '{
    1048576, 1028428, 968757, 871859, 741455, 582557, 401273, 204567, 0
  };

  function automatic int acc_width(input int dw, input int cw);
    return dw + 1 + cw + 3;
  endfunction

  // C[k][n] = round_half_away(c(k) * cos((2n+1)k*pi/16) * 2^(cw-1)).
  // c(0)*2^(cw-1) equals cos(pi/4)*2^(cw-2), so row 0 reuses the m=4 entry.
  function automatic int cos_coeff(input int k, input int n, input int cw);
    int     m;
    int     sgn;
    longint mag;
    m   = ((2 * n + 1) * k) % 32;
    sgn = 1;
    if (m > 16) begin
      m = 32 - m;
    end
    if (m > 8) begin
      m   = 16 - m;
      sgn = -1;
    end
    if (k == 0) begin
      m   = 4;
      sgn = 1;
    end
    mag = ((longint'(COS_TAB[m]) << (cw - 2)) + (64'sd1 << (COS_FRAC_BITS - 1)))
          >>> COS_FRAC_BITS;
    return (sgn < 0) ? -int'(mag) : int'(mag);
  endfunction

endpackage

// File: rtl/dct_dot8.sv
// One DCT output coefficient: full-precision dot product of eight samples with
// a selected cosine row, rounded half up and saturated to OUTPUT_WIDTH.
module dct_dot8
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OUTPUT_WIDTH = 12,
  parameter int COEFF_WIDTH  = 12,
  parameter bit SIGNED_IN    = 1'b0
) (
  input  logic [7:0][DATA_WIDTH-1:0]     samples,
  input  logic [2:0]                     row,
  output logic signed [OUTPUT_WIDTH-1:0] result
);

  localparam int ACC_W  = acc_width(DATA_WIDTH, COEFF_WIDTH);
  localparam int PROD_W = DATA_WIDTH + 1 + COEFF_WIDTH;
  localparam logic signed [ACC_W-1:0] RND_HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (COEFF_WIDTH - 2);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(ACC_W-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(ACC_W-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

  logic signed [COEFF_WIDTH-1:0] coef_tab_s [8][8];
  logic signed [PROD_W-1:0]      prod_s [8];
  logic signed [ACC_W-1:0]       acc_s;
  logic signed [ACC_W-1:0]       rnd_s;

  for (genvar gk = 0; gk < 8; gk++) begin : g_row
    for (genvar gn = 0; gn < 8; gn++) begin : g_col
      localparam int C_VAL = cos_coeff(gk, gn, COEFF_WIDTH);
      assign coef_tab_s[gk][gn] = C_VAL[COEFF_WIDTH-1:0];
    end
  end

  for (genvar gn = 0; gn < 8; gn++) begin : g_mul
    logic signed [DATA_WIDTH:0] xe_s;
    assign xe_s = SIGNED_IN ? $signed({samples[gn][DATA_WIDTH-1], samples[gn]})
                            : $signed({1'b0, samples[gn]});
    assign prod_s[gn] = PROD_W'(xe_s) * PROD_W'(coef_tab_s[row][gn]);
  end

  // accumulate, round half up, arithmetic shift, then clamp
  always_comb begin
    acc_s = '0;
    for (int n = 0; n < 8; n++) begin
      acc_s = acc_s + ACC_W'(prod_s[n]);
    end
    rnd_s = (acc_s + RND_HALF) >>> (COEFF_WIDTH - 1);
    if (rnd_s > SAT_MAX) begin
      result = SAT_MAX[OUTPUT_WIDTH-1:0];
    end else if (rnd_s < SAT_MIN) begin
      result = SAT_MIN[OUTPUT_WIDTH-1:0];
    end else begin
      result = rnd_s[OUTPUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/dct_stage.sv
// 8-point 1-D DCT-II stage: gathers four two-sample beats, snapshots the block,
// then emits X0/X1..X6/X7 as four registered pairs with a sync on X0/X1.
module dct_stage
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OUTPUT_WIDTH = 12,
  parameter int COEFF_WIDTH  = 12,
  parameter bit SIGNED_IN    = 1'b0
) (
  input  logic                           i_clk,
  input  logic                           i_resetn,
  input  logic [DATA_WIDTH-1:0]          i_p0,
  input  logic [DATA_WIDTH-1:0]          i_p1,
  input  logic                           i_vld,
  output logic signed [OUTPUT_WIDTH-1:0] o_c0,
  output logic signed [OUTPUT_WIDTH-1:0] o_c1,
  output logic                           o_sync
);

  logic [1:0]                     beat_r;
  logic [5:0][DATA_WIDTH-1:0]     samp_r;
  logic [7:0][DATA_WIDTH-1:0]     snap_r;
  seq_state_t                     state_r;
  logic [1:0]                     pair_r;
  logic                           pipe_vld_r;
  logic                           pipe_sync_r;
  logic signed [OUTPUT_WIDTH-1:0] pipe_c0_r;
  logic signed [OUTPUT_WIDTH-1:0] pipe_c1_r;
  logic signed [OUTPUT_WIDTH-1:0] even_s;
  logic signed [OUTPUT_WIDTH-1:0] odd_s;
  logic                           last_beat_s;

  assign last_beat_s = i_vld && (beat_r == 2'd3);

  // beat collection; the final beat copies the whole block into the snapshot
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      beat_r <= 2'd0;
      samp_r <= '0;
      snap_r <= '0;
    end else if (i_vld) begin
      beat_r <= beat_r + 2'd1;
      case (beat_r)
        2'd0: begin
          samp_r[0] <= i_p0;
          samp_r[1] <= i_p1;
        end
        2'd1: begin
          samp_r[2] <= i_p0;
          samp_r[3] <= i_p1;
        end
        2'd2: begin
          samp_r[4] <= i_p0;
          samp_r[5] <= i_p1;
        end
        2'd3: snap_r <= {i_p1, i_p0, samp_r};
        default: ;
      endcase
    end
  end

  // output pair sequencer; a new block landing on pair 3 restarts at pair 0
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_r <= SEQ_IDLE;
      pair_r  <= 2'd0;
    end else begin
      case (state_r)
        SEQ_IDLE: begin
          if (last_beat_s) begin
            state_r <= SEQ_RUN;
          end
          pair_r <= 2'd0;
        end
        SEQ_RUN: begin
          if (last_beat_s) begin
            pair_r <= 2'd0;
          end else if (pair_r == 2'd3) begin
            state_r <= SEQ_IDLE;
            pair_r  <= 2'd0;
          end else begin
            pair_r <= pair_r + 2'd1;
          end
        end
        default: begin
          state_r <= SEQ_IDLE;
          pair_r  <= 2'd0;
        end
      endcase
    end
  end

  dct_dot8 #(
    .DATA_WIDTH  (DATA_WIDTH),
    .OUTPUT_WIDTH(OUTPUT_WIDTH),
    .COEFF_WIDTH (COEFF_WIDTH),
    .SIGNED_IN   (SIGNED_IN)
  ) u_dot_even (
    .samples(snap_r),
    .row    ({pair_r, 1'b0}),
    .result (even_s)
  );

  dct_dot8 #(
    .DATA_WIDTH  (DATA_WIDTH),
    .OUTPUT_WIDTH(OUTPUT_WIDTH),
    .COEFF_WIDTH (COEFF_WIDTH),
    .SIGNED_IN   (SIGNED_IN)
  ) u_dot_odd (
    .samples(snap_r),
    .row    ({pair_r, 1'b1}),
    .result (odd_s)
  );

  // result pipeline then output registers; outputs hold between pairs
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      pipe_vld_r  <= 1'b0;
      pipe_sync_r <= 1'b0;
      pipe_c0_r   <= '0;
      pipe_c1_r   <= '0;
      o_c0        <= '0;
      o_c1        <= '0;
      o_sync      <= 1'b0;
    end else begin
      pipe_vld_r  <= (state_r == SEQ_RUN);
      pipe_sync_r <= (state_r == SEQ_RUN) && (pair_r == 2'd0);
      if (state_r == SEQ_RUN) begin
        pipe_c0_r <= even_s;
        pipe_c1_r <= odd_s;
      end
      o_sync <= pipe_sync_r;
      if (pipe_vld_r) begin
        o_c0 <= pipe_c0_r;
        o_c1 <= pipe_c1_r;
      end
    end
  end

endmodule

// File: tb/tb_dct_stage.sv
// Self-checking bench for dct_stage: unsigned and signed instances driven in
// parallel, checked every cycle against a real-arithmetic DCT reference model.
module tb_dct_stage;

  localparam int  CW = 12;
  localparam real PI = 3.14159265358979323846;

  typedef struct {
    int at_edge;
    int u0, u1, s0, s1;
    bit sync;
  } exp_t;

  typedef struct {
    logic [7:0] x [8];
    int         expv [8];
  } vec_t;

  logic              clk;
  logic              i_resetn;
  logic [7:0]        i_p0, i_p1;
  logic              i_vld;
  logic signed [11:0] c0_u, c1_u, c0_s, c1_s;
  logic              sync_u, sync_s;

  int   total = 0;
  int   bad = 0;
  int   edge_n = 0;
  int   mdl_beat = 0;
  logic [7:0] mdl_blk [8];
  exp_t exp_q [$];
  int   last_u0 = 0, last_u1 = 0, last_s0 = 0, last_s1 = 0;
  vec_t tab [2];

  dct_stage #(.DATA_WIDTH(8), .OUTPUT_WIDTH(12), .COEFF_WIDTH(12), .SIGNED_IN(1'b0)) dut_u (
    .i_clk(clk), .i_resetn(i_resetn), .i_p0(i_p0), .i_p1(i_p1), .i_vld(i_vld),
    .o_c0(c0_u), .o_c1(c1_u), .o_sync(sync_u));

  dct_stage #(.DATA_WIDTH(8), .OUTPUT_WIDTH(12), .COEFF_WIDTH(12), .SIGNED_IN(1'b1)) dut_s (
    .i_clk(clk), .i_resetn(i_resetn), .i_p0(i_p0), .i_p1(i_p1), .i_vld(i_vld),
    .o_c0(c0_s), .o_c1(c1_s), .o_sync(sync_s));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, req, edge_n);
    end
  endtask

  function automatic int coef_ref(input int k, input int n);
    real c, v;
    c = (k == 0) ? 1.0 / (2.0 * $sqrt(2.0)) : 0.5;
    v = c * $cos(real'((2 * n + 1) * k) * PI / 16.0) * real'(1 << (CW - 1));
    if (v >= 0.0) return $rtoi($floor(v + 0.5));
    else return -$rtoi($floor(-v + 0.5));
  endfunction

  function automatic int dct_ref(input logic [7:0] x [8], input bit sgn, input int k);
    longint acc, xi;
    acc = 0;
    for (int n = 0; n < 8; n++) begin
      if (sgn) xi = longint'($signed(x[n]));
      else xi = longint'(x[n]);
      acc += xi * coef_ref(k, n);
    end
    acc = (acc + (64'sd1 <<< (CW - 2))) >>> (CW - 1);
    if (acc > 2047) acc = 2047;
    if (acc < -2048) acc = -2048;
    return int'(acc);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_block(input int t);
    exp_t r;
    for (int p = 0; p < 4; p++) begin
      r.at_edge = t + 2 + p;
      r.u0 = dct_ref(mdl_blk, 1'b0, 2 * p);
      r.u1 = dct_ref(mdl_blk, 1'b0, 2 * p + 1);
      r.s0 = dct_ref(mdl_blk, 1'b1, 2 * p);
      r.s1 = dct_ref(mdl_blk, 1'b1, 2 * p + 1);
      r.sync = (p == 0);
      exp_q.push_back(r);
    end
  endtask

  task automatic drive_beat(input logic [7:0] p0, input logic [7:0] p1);
    i_p0 = p0;
    i_p1 = p1;
    i_vld = 1'b1;
    mdl_blk[2 * mdl_beat] = p0;
    mdl_blk[2 * mdl_beat + 1] = p1;
    if (mdl_beat == 3) push_block(edge_n + 1);
    mdl_beat = (mdl_beat + 1) % 4;
    step();
  endtask

  task automatic idle(input int n);
    i_vld = 1'b0;
    for (int i = 0; i < n; i++) begin
      i_p0 = 8'($urandom());
      i_p1 = 8'($urandom());
      step();
    end
  endtask

  task automatic send_block(input logic [7:0] x [8], input int gap_after, input int gap_len);
    for (int b = 0; b < 4; b++) begin
      drive_beat(x[2 * b], x[2 * b + 1]);
      if (b == gap_after && gap_len > 0 && b < 3) idle(gap_len);
    end
  endtask

  // called right after the edge that accepted beat 3
  task automatic check_pairs(input int expv [8], input string tag);
    idle(1);
    for (int p = 0; p < 4; p++) begin
      idle(1);
      chk({tag, "_sync"}, sync_u, (p == 0) ? 1 : 0);
      chk({tag, "_c0"}, c0_u, expv[2 * p]);
      chk({tag, "_c1"}, c1_u, expv[2 * p + 1]);
    end
  endtask

  task automatic do_reset(input int n);
    i_resetn = 1'b0;
    exp_q.delete();
    mdl_beat = 0;
    last_u0 = 0; last_u1 = 0; last_s0 = 0; last_s1 = 0;
    for (int i = 0; i < n; i++) begin
      i_p0 = 8'($urandom());
      i_p1 = 8'($urandom());
      i_vld = 1'($urandom());
      step();
      chk("rst_c0", c0_u, 0);
      chk("rst_c1", c1_u, 0);
      chk("rst_sync", sync_u, 0);
      chk("rst_sync_s", sync_s, 0);
    end
    i_vld = 1'b0;
    i_resetn = 1'b1;
  endtask

  // cycle monitor: every edge is either a scheduled pair or a hold cycle
  initial begin
    exp_t r;
    forever begin
      @(posedge clk);
      edge_n++;
      #2;
      if (exp_q.size() > 0 && exp_q[0].at_edge == edge_n) begin
        r = exp_q.pop_front();
        chk("mon_sync_u", sync_u, r.sync);
        chk("mon_sync_s", sync_s, r.sync);
        chk("mon_c0_u", c0_u, r.u0);
        chk("mon_c1_u", c1_u, r.u1);
        chk("mon_c0_s", c0_s, r.s0);
        chk("mon_c1_s", c1_s, r.s1);
        last_u0 = r.u0; last_u1 = r.u1; last_s0 = r.s0; last_s1 = r.s1;
      end else begin
        chk("hold_sync_u", sync_u, 0);
        chk("hold_sync_s", sync_s, 0);
        chk("hold_c0_u", c0_u, last_u0);
        chk("hold_c1_u", c1_u, last_u1);
        chk("hold_c0_s", c0_s, last_s0);
        chk("hold_c1_s", c1_s, last_s1);
      end
    end
  end

  initial begin
    logic [7:0] rx [8];
    tab[0].x    = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    tab[0].expv = '{13, -6, 0, -1, 0, 0, 0, 0};
    tab[1].x    = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    tab[1].expv = '{721, 0, 0, 0, 0, 0, 0, 0};

    i_resetn = 1'b0;
    i_vld = 1'b0;
    i_p0 = 8'd0;
    i_p1 = 8'd0;
    do_reset(5);
    idle(2);

    for (int v = 0; v < 2; v++) begin
      send_block(tab[v].x, 0, 0);
      check_pairs(tab[v].expv, (v == 0) ? "ramp" : "dc");
      idle(2);
    end

    send_block(tab[0].x, 1, 3);
    check_pairs(tab[0].expv, "gapped");
    idle(2);

    send_block(tab[0].x, 0, 0);
    send_block(tab[1].x, 0, 0);
    check_pairs(tab[1].expv, "b2b_dc");
    idle(2);

    for (int b = 0; b < 3; b++) drive_beat(tab[1].x[2 * b], tab[1].x[2 * b + 1]);
    do_reset(2);
    idle(1);
    send_block(tab[0].x, 0, 0);
    check_pairs(tab[0].expv, "post_rst");
    idle(3);

    for (int blk = 0; blk < 24; blk++) begin
      for (int n = 0; n < 8; n++) rx[n] = 8'($urandom());
      send_block(rx, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      idle(int'($urandom_range(0, 3)));
    end

    idle(8);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dct_stage.md
Name: dct_stage

Overview:
Single 8-point 1-D DCT-II stage of the pixel-block compressor datapath. Accepts two samples per clock and collects one 8-sample row or column in four valid beats. It emits the eight fixed-point DCT coefficients as four consecutive output pairs, with a sync pulse marking coefficient pair X0/X1. Two instances in series, with a transpose between them, form the 2-D DCT.

Parameters:
DATA_WIDTH, 8, input sample width.
OUTPUT_WIDTH, 12, output coefficient width, signed two's complement.
COEFF_WIDTH, 12, signed width of the cosine constants.
SIGNED_IN, 0, 0 = inputs are unsigned pixels (zero-extended); 1 = inputs are signed two's complement.

Ports:
i_clk  in  1  clock, rising edge.
i_resetn  in  1  asynchronous active-low reset.
i_p0  in  DATA_WIDTH  even sample of the current beat (x0, x2, x4, x6).
i_p1  in  DATA_WIDTH  odd sample of the current beat (x1, x3, x5, x7).
i_vld  in  1  beat valid; samples are sampled on the rising edge when high.
o_c0  out  OUTPUT_WIDTH  even-index coefficient of the current pair (X0, X2, X4, X6).
o_c1  out  OUTPUT_WIDTH  odd-index coefficient of the current pair (X1, X3, X5, X7).
o_sync  out  1  one-cycle pulse, high while o_c0/o_c1 carry X0/X1.

Behaviour:
- Reset: asynchronous and active-low on i_resetn, one clock i_clk. While reset is asserted:
  - o_c0, o_c1 and o_sync are 0;
  - the beat counter is 0;
  - in-flight blocks are discarded.
- Input beats: a 2-bit beat counter advances only on edges where i_vld=1.
  - Beat b (0..3) loads x[2b]=i_p0 and x[2b+1]=i_p1.
  - i_vld low mid-block pauses the counter; partial data is retained.
  - The counter wraps 3->0, so back-to-back blocks stream with no gap.
- Transform: X[k] = sum over n=0..7 of x[n]*C[k][n].
  - C[k][n] = round_half_away(c(k)*cos((2n+1)k*pi/16) * 2^(COEFF_WIDTH-1)).
  - c(0) = 1/(2*sqrt2); c(k>0) = 1/2 (orthonormal scaling).
- Width rules:
  - Products and the accumulator are full precision, with no intermediate truncation.
  - Result = (acc + 2^(COEFF_WIDTH-2)) >>> (COEFF_WIDTH-1), i.e. round half up, arithmetic shift.
  - The result then saturates to the signed OUTPUT_WIDTH range.
- Timing: let edge T accept beat 3 of a block.
  - Edge T+2: X0/X1 registered, o_sync=1 for that one cycle.
  - Edge T+3: X2/X3. Edge T+4: X4/X5. Edge T+5: X6/X7.
  - o_sync is 0 on every other cycle.
- Outputs are registered and hold their last value until the next pair is produced.
- With continuous i_vld, a new block's X0/X1 follows X6/X7 on the next cycle. The block must therefore be snapshotted at edge T so beats of the next block can overwrite the input buffer.
- Output sequencing continues even if i_vld drops after beat 3.
- Reset mid-operation: immediate return to reset values; the next accepted beat is beat 0.

Decomposition:
- Package dct_pkg holds:
  - the 8x8 cosine constant table, generated from COEFF_WIDTH;
  - the accumulator width constant: DATA_WIDTH+1+COEFF_WIDTH+3.
- Sub-module dct_dot8 takes 8 samples and a selected row k, and returns the rounded, saturated X[k].
- dct_stage instantiates dct_dot8 twice (even row and odd row), driven by a 2-bit output-pair counter.

Test Plan:
- Reset: hold i_resetn=0 with toggling inputs -> o_c0=o_c1=0, o_sync=0 throughout.
- Ramp block: beats (1,2),(3,4),(5,6),(7,8) with i_vld=1 -> o_sync at T+2 with (13,-6), then (0,-1), (0,0), (0,0).
- DC block: all samples 255 -> pairs (721,0),(0,0),(0,0),(0,0).
- Gapped input: same ramp with i_vld=0 for 3 cycles between beats 1 and 2 -> identical coefficients; sync is 2 edges after the final beat.
- Back-to-back: ramp block immediately followed by the all-255 block -> o_sync pulses exactly 4 cycles apart, with correct values for both blocks.
- Mid-block reset: assert i_resetn=0 after beat 2, release, then send the ramp -> no sync for the aborted block; ramp results are correct.
- Random blocks, SIGNED_IN=0 and SIGNED_IN=1 -> bit-exact match to the integer model defined above.
